add_pipe_nbit: RTL



---
 rtl/add_pipe_nbit_pkg.sv | 36 +++
 rtl/add_pipe_nbit_if.sv | 27 ++
 rtl/add_pipe_nbit_chunk.sv | 42 ++++
 rtl/add_pipe_nbit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/add_pipe_nbit_pkg.sv
// Shared types, width rules and saturation constants for the pipelined adder.
// MAX_N bounds the operand width that the helper functions can describe.
package add_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int MAX_N = 64;

  function automatic int chunk_width(input int n, input int stages);
    return n / stages;
  endfunction

  function automatic bit chunk_ok(input int n, input int stages);
    return (stages > 0) && (n > 0) && (n <= MAX_N) && ((n % stages) == 0);
  endfunction

  // Largest positive two's-complement value of an n-bit word (0x7F..F).
  function automatic logic [MAX_N-1:0] max_pos(input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < n - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Most negative two's-complement value of an n-bit word (0x80..0).
  function automatic logic [MAX_N-1:0] max_neg(input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    r[n-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/add_pipe_nbit_if.sv
// Operand and result handshake bundle for add_pipe_nbit.
// master = operand producer / result consumer, slave = the adder.
interface add_pipe_nbit_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         c_out;
  logic         ovf;

  modport master (
    output in_valid, x, y, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, x, y, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/add_pipe_nbit_chunk.sv
// Combinational W-bit ripple adder built from Full_adder cells.
// Latency 0; no handshake, pure logic. c_msb is the carry into the top bit.
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_chunk
  import add_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    Full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[W];
  assign c_msb = c[W-1];
endmodule

// File: rtl/add_pipe_nbit.sv
// Pipelined N-bit add/sub, one CHUNK per stage; ADD_PIPE_SAT_EN adds signed clamping.
// Latency STAGES cycles from acceptance, throughput 1/cycle.
// out_valid && !out_ready freezes every stage; in_ready = !out_valid || out_ready.
module add_pipe_nbit
  import add_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic           clk,
  input  logic           rst,
  add_pipe_nbit_if.slave bus
);
  localparam int CHUNK = chunk_width(N, STAGES);

  if (!chunk_ok(N, STAGES)) begin : g_bad_cfg
    $error("add_pipe_nbit: N must be a non-zero multiple of STAGES and at most MAX_N");
  end

  logic         adv;
  op_e          op;
  logic [N-1:0] y_eff;
  logic         c0;

  assign op    = op_e'(bus.sub);
  assign y_eff = (op == OP_SUB) ? ~bus.y : bus.y;
  assign c0    = (op == OP_SUB) ? 1'b1 : bus.c_in;
  assign adv   = !bus.out_valid || bus.out_ready;

  // Each stage registers the full skewed operands plus the partially built
  // result; chunk k of the result is written by stage k and then carried along.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [N-1:0]     xi;
    logic [N-1:0]     yi;
    logic [N-1:0]     ri;
    logic [N-1:0]     rn;
    logic [N-1:0]     rd;
    logic             ci;
    logic             vi;
    logic [CHUNK-1:0] sum;
    logic             co;
    logic             cm;

    logic             vq;
    logic             cq;
    logic [N-1:0]     xq;
    logic [N-1:0]     yq;
    logic [N-1:0]     rq;

    if (k == 0) begin : g_first
      assign xi = bus.x;
      assign yi = y_eff;
      assign ri = '0;
      assign ci = c0;
      assign vi = bus.in_valid;
    end else begin : g_next
      assign xi = g_stage[k-1].xq;
      assign yi = g_stage[k-1].yq;
      assign ri = g_stage[k-1].rq;
      assign ci = g_stage[k-1].cq;
      assign vi = g_stage[k-1].vq;
    end

    add_chunk #(.W(CHUNK)) u_chunk (
      .a     (xi[k*CHUNK +: CHUNK]),
      .b     (yi[k*CHUNK +: CHUNK]),
      .ci    (ci),
      .s     (sum),
      .co    (co),
      .c_msb (cm)
    );

    always_comb begin
      rn = ri;
      rn[k*CHUNK +: CHUNK] = sum;
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_n;
      logic ovf_q;
      logic unused_skew;

      assign ovf_n       = cm ^ co;
      assign unused_skew = ^{xq, yq};

`ifdef ADD_PIPE_SAT_EN
      localparam logic [MAX_N-1:0] SAT_POS_W = max_pos(N);
      localparam logic [MAX_N-1:0] SAT_NEG_W = max_neg(N);
      localparam logic [N-1:0]     SAT_POS   = SAT_POS_W[N-1:0];
      localparam logic [N-1:0]     SAT_NEG   = SAT_NEG_W[N-1:0];

      // On overflow both effective operand signs agree; a clear sign means the
      // true result is positive.
      always_comb begin
        rd = rn;
        if (ovf_n) rd = (!xi[N-1] && !yi[N-1]) ? SAT_POS : SAT_NEG;
      end
`else
      assign rd = rn;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_n;
        end
      end
    end else begin : g_mid
      logic unused_msb;
      assign unused_msb = cm;
      assign rd         = rn;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vq <= 1'b0;
        cq <= 1'b0;
        xq <= '0;
        yq <= '0;
        rq <= '0;
      end else if (adv) begin
        vq <= vi;
        cq <= co;
        xq <= xi;
        yq <= yi;
        rq <= rd;
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = g_stage[STAGES-1].vq;
  assign bus.s         = g_stage[STAGES-1].rq;
  assign bus.c_out     = g_stage[STAGES-1].cq;
  assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
